// File: rtl/phy_tx_if.sv
// rtl/phy_tx_if.sv - SIE-to-PHY transmit byte handshake bundle
// Signals:
//   tx_valid  SIE has a byte on tx_data; held high for the whole packet
//   tx_data   byte to transmit, LSB first
//   tx_ready  one-clk pulse from the PHY: tx_data captured on the edge ending it
// Modports: master = SIE side, slave = PHY side.
interface phy_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/phy_tx.sv
// rtl/phy_tx.sv - USB 2.0 full-speed transmit PHY: SYNC, LSB-first shift, bit stuffing, NRZI, EOP
// Ports:
//   clk_i      clock, 12MHz*BIT_SAMPLES
//   rstn_i     asynchronous active-low reset
//   tx_en_i    block enable; low aborts to IDLE on the next clk
//   sie_if     slave side of phy_tx_if (tx_valid/tx_data in, tx_ready out)
//   tx_en_o    output enable for the dp/dn drivers
//   dp_tx_o    dp line value
//   dn_tx_o    dn line value
// Build option: PHY_TX_IDLE_GAP_EN holds IDLE for 2 extra bit times after each packet.
module phy_tx #(
    parameter int BIT_SAMPLES = 4
) (
    input  logic    clk_i,
    input  logic    rstn_i,
    input  logic    tx_en_i,
    phy_tx_if.slave sie_if,
    output logic    tx_en_o,
    output logic    dp_tx_o,
    output logic    dn_tx_o
);
    localparam int CW = (BIT_SAMPLES > 2) ? $clog2(BIT_SAMPLES) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_EOP  = 3'd3;
    localparam logic [2:0] S_J    = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_bit_cnt;
    logic [2:0]    r_bit_idx;    // index of the data bit on the line (EOP: SE0 count)
    logic [2:0]    r_stuff_cnt;  // consecutive 1s already on the line
    logic [6:0]    r_shift;      // bits still to send after the one on the line
    logic          r_ready;
    logic          r_tx_en;
    logic          r_dp;
    logic          r_dn;

    logic w_wrap;
    logic w_pre_wrap;
    logic w_stuff_due;
    logic w_last_bit;
    logic w_emit_bit;
    logic w_gap_done;

    assign w_wrap      = (r_bit_cnt == CW'(BIT_SAMPLES - 1));
    assign w_pre_wrap  = (r_bit_cnt == CW'(BIT_SAMPLES - 2));
    assign w_stuff_due = (r_stuff_cnt == 3'd6);
    // Byte boundary: final bit of the byte is on the line and no stuff bit follows it
    assign w_last_bit  = (r_bit_idx == 3'd7) && !w_stuff_due;
    assign w_emit_bit  = w_last_bit ? sie_if.tx_data[0] : r_shift[0];

`ifdef PHY_TX_IDLE_GAP_EN
    localparam int GW = $clog2(2 * BIT_SAMPLES);
    logic [GW-1:0] r_gap;

    // Counts down the enforced inter-packet gap; start is allowed once it reaches 0
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_gap <= '0;
        end else if (!tx_en_i) begin
            r_gap <= '0;
        end else if (r_state == S_J && w_wrap) begin
            r_gap <= GW'(2 * BIT_SAMPLES - 1);
        end else if (r_state == S_IDLE && r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
        end
    end
    assign w_gap_done = (r_gap == '0);
`else
    assign w_gap_done = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_stuff_cnt <= '0;
            r_shift     <= '0;
            r_ready     <= 1'b0;
            r_tx_en     <= 1'b0;
            r_dp        <= 1'b1;
            r_dn        <= 1'b0;
        end else if (!tx_en_i) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_stuff_cnt <= '0;
            r_ready     <= 1'b0;
            r_tx_en     <= 1'b0;
            r_dp        <= 1'b1;
            r_dn        <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (r_state != S_IDLE) begin
                r_bit_cnt <= w_wrap ? '0 : r_bit_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt   <= '0;
                    r_bit_idx   <= '0;
                    r_stuff_cnt <= '0;
                    r_tx_en     <= 1'b0;
                    r_dp        <= 1'b1;
                    r_dn        <= 1'b0;
                    if (sie_if.tx_valid && w_gap_done) begin
                        // SYNC 0x80: bit 0 (a 0) goes out now as K, bits 1..7 queued
                        r_state <= S_SYNC;
                        r_shift <= 7'b1000000;
                        r_tx_en <= 1'b1;
                        r_dp    <= 1'b0;
                        r_dn    <= 1'b1;
                    end
                end
                S_SYNC, S_DATA: begin
                    // Ready is registered, so decide one clk before the boundary edge
                    if (w_pre_wrap && w_last_bit && sie_if.tx_valid) begin
                        r_ready <= 1'b1;
                    end
                    if (w_wrap) begin
                        if (w_stuff_due) begin
                            // Stuffed 0: toggle without consuming a data bit
                            r_stuff_cnt <= '0;
                            r_dp        <= ~r_dp;
                            r_dn        <= r_dp;
                        end else if (w_last_bit && !r_ready) begin
                            r_state     <= S_EOP;
                            r_bit_idx   <= '0;
                            r_stuff_cnt <= '0;
                            r_dp        <= 1'b0;
                            r_dn        <= 1'b0;
                        end else begin
                            if (w_last_bit) begin
                                r_state   <= S_DATA;
                                r_shift   <= sie_if.tx_data[7:1];
                                r_bit_idx <= '0;
                            end else begin
                                r_shift   <= {1'b0, r_shift[6:1]};
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                            // NRZI: 1 holds the line, 0 toggles it
                            if (w_emit_bit) begin
                                r_stuff_cnt <= r_stuff_cnt + 3'd1;
                            end else begin
                                r_stuff_cnt <= '0;
                                r_dp        <= ~r_dp;
                                r_dn        <= r_dp;
                            end
                        end
                    end
                end
                S_EOP: begin
                    if (w_wrap) begin
                        if (r_bit_idx == 3'd0) begin
                            r_bit_idx <= 3'd1;
                        end else begin
                            r_state <= S_J;
                            r_dp    <= 1'b1;
                            r_dn    <= 1'b0;
                        end
                    end
                end
                S_J: begin
                    if (w_wrap) begin
                        r_state <= S_IDLE;
                        r_tx_en <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx_en <= 1'b0;
                    r_dp    <= 1'b1;
                    r_dn    <= 1'b0;
                end
            endcase
        end
    end

    assign sie_if.tx_ready = r_ready;
    assign tx_en_o         = r_tx_en;
    assign dp_tx_o         = r_dp;
    assign dn_tx_o         = r_dn;
endmodule

// File: tb/tb_phy_tx.sv
// tb/tb_phy_tx.sv - self-checking bench for phy_tx
module tb_phy_tx;
    localparam int BS = 4;
`ifdef PHY_TX_IDLE_GAP_EN
    localparam int GAP_EXP = 2 * BS;
`else
    localparam int GAP_EXP = 1;
`endif

    typedef struct {
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        bit         scramble;
        string      exp_sym;
        int         exp_en;
        string      exp_rdy;
    } vec_t;

    logic clk_i = 1'b0;
    logic rstn_i;
    logic tx_en_i;
    logic tx_en_o;
    logic dp_tx_o;
    logic dn_tx_o;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vt [0:5];

    phy_tx_if sie_if ();

    phy_tx #(.BIT_SAMPLES(BS)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .tx_en_i (tx_en_i),
        .sie_if  (sie_if),
        .tx_en_o (tx_en_o),
        .dp_tx_o (dp_tx_o),
        .dn_tx_o (dn_tx_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_str(input string nm, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input bit scr, input string sym, input int en, input string rdy);
        vec_t v;
        v.nbytes = n; v.b0 = b0; v.b1 = b1; v.scramble = scr;
        v.exp_sym = sym; v.exp_en = en; v.exp_rdy = rdy;
        return v;
    endfunction

    function automatic logic [7:0] byte_at(input vec_t v, input int i);
        return (i == 0) ? v.b0 : ((i == 1) ? v.b1 : 8'h00);
    endfunction

    // Drives one packet as the SIE and records the line per clk while tx_en_o is high.
    task automatic run_packet(input vec_t v, input string nm);
        logic [1:0] smp [0:1023];
        int    lat, en_cnt, sent;
        bit    started, done, uni;
        string sym, rdy;
        lat = 0; en_cnt = 0; sent = 0; started = 0; done = 0;
        sym = ""; rdy = "";
        sie_if.tx_valid = 1'b1;
        sie_if.tx_data  = v.b0;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk_i);
            if (!started) begin
                lat++;
                if (tx_en_o) started = 1;
            end
            if (started) begin
                if (tx_en_o && en_cnt < 1024) begin
                    smp[en_cnt] = {dp_tx_o, dn_tx_o};
                    if (sie_if.tx_ready) rdy = {rdy, $sformatf("%0d,", en_cnt)};
                    en_cnt++;
                end else begin
                    done = 1;
                end
            end
            if (sie_if.tx_ready) begin
                sie_if.tx_data = byte_at(v, sent);
                sent++;
            end else begin
                sie_if.tx_valid = started ? (sent < v.nbytes) : 1'b1;
                sie_if.tx_data  = v.scramble ? 8'($urandom) : byte_at(v, sent);
            end
        end
        sie_if.tx_valid = 1'b0;
        chk_int({nm, "_finished"}, int'(done), 1);
        chk_int({nm, "_start_latency"}, lat, 1);
        for (int b = 0; b < en_cnt / BS; b++) begin
            uni = 1;
            for (int k = 1; k < BS; k++) if (smp[b*BS+k] !== smp[b*BS]) uni = 0;
            if (!uni) sym = {sym, "?"};
            else case (smp[b*BS])
                2'b10:   sym = {sym, "J"};
                2'b01:   sym = {sym, "K"};
                2'b00:   sym = {sym, "0"};
                default: sym = {sym, "X"};
            endcase
        end
        chk_str({nm, "_symbols"}, sym, v.exp_sym);
        chk_int({nm, "_tx_en_clks"}, en_cnt, v.exp_en);
        chk_str({nm, "_ready_clks"}, rdy, v.exp_rdy);
        repeat (2 * BS + 2) @(negedge clk_i);
    endtask

    initial begin
        bit ok;
        int gap;
        vt[0] = mk(1, 8'h00, 8'h00, 0, "KJKJKJKKJKJKJKJK00J", 76, "31,");
        vt[1] = mk(1, 8'hFF, 8'h00, 0, "KJKJKJKKKKKKKJJJJ00J", 80, "31,");
        vt[2] = mk(2, 8'h3F, 8'h01, 1, "KJKJKJKKKKKKKJJKJJKJKJKJK00J", 112, "31,67,");
        vt[3] = mk(0, 8'h00, 8'h00, 0, "KJKJKJKK00J", 44, "");
        vt[4] = mk(1, 8'hFC, 8'h00, 0, "KJKJKJKKJKKKKKKKJ00J", 80, "31,");
        vt[5] = mk(2, 8'hFF, 8'hFF, 0, "KJKJKJKKKKKKKJJJJJJJKKKKKK00J", 116, "31,67,");

        rstn_i = 1'b0;
        tx_en_i = 1'b1;
        sie_if.tx_valid = 1'b0;
        sie_if.tx_data = 8'h00;
        repeat (2) @(negedge clk_i);
        chk_int("reset_outputs", int'({dp_tx_o, dn_tx_o, tx_en_o, sie_if.tx_ready}), 4'b1000);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk_int("idle_outputs", int'({dp_tx_o, dn_tx_o, tx_en_o, sie_if.tx_ready}), 4'b1000);

        for (int i = 0; i < 6; i++) run_packet(vt[i], $sformatf("vec%0d", i));

        // Abort during data bit 3, then a clean restart
        sie_if.tx_valid = 1'b1;
        sie_if.tx_data = 8'h00;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk_i);
            if (tx_en_o) ok = 1;
        end
        chk_int("abort_start", int'(ok), 1);
        repeat (45) @(negedge clk_i);
        tx_en_i = 1'b0;
        @(negedge clk_i);
        chk_int("abort_lines", int'({dp_tx_o, dn_tx_o, tx_en_o, sie_if.tx_ready}), 4'b1000);
        repeat (3) @(negedge clk_i);
        chk_int("abort_hold_idle", int'({dp_tx_o, dn_tx_o, tx_en_o}), 3'b100);
        tx_en_i = 1'b1;
        run_packet(vt[0], "restart");

        // Back-to-back packets with tx_valid_i held high across the J state
        sie_if.tx_valid = 1'b1;
        sie_if.tx_data = 8'h00;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk_i);
            if (tx_en_o) ok = 1;
        end
        chk_int("gap_first_start", int'(ok), 1);
        sie_if.tx_valid = 1'b0;
        repeat (40) @(negedge clk_i);
        chk_int("gap_j_state", int'({dp_tx_o, dn_tx_o, tx_en_o}), 3'b101);
        sie_if.tx_valid = 1'b1;
        gap = 0;
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk_i);
            if (!tx_en_o) gap++;
            else if (gap > 0) ok = 1;
        end
        chk_int("gap_second_start", int'(ok), 1);
        chk_int("gap_idle_clks", gap, GAP_EXP);
        chk_int("gap_second_first_k", int'({dp_tx_o, dn_tx_o}), 2'b01);
        sie_if.tx_valid = 1'b0;
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk_i);
            if (!tx_en_o) ok = 1;
        end
        chk_int("gap_second_end", int'(ok), 1);
        repeat (2 * BS + 2) @(negedge clk_i);

        // Asynchronous reset mid-packet
        sie_if.tx_valid = 1'b1;
        sie_if.tx_data = 8'hFF;
        repeat (20) @(negedge clk_i);
        chk_int("pre_reset_active", int'(tx_en_o), 1);
        #1;
        rstn_i = 1'b0;
        #1;
        chk_int("async_reset_outputs", int'({dp_tx_o, dn_tx_o, tx_en_o, sie_if.tx_ready}), 4'b1000);
        sie_if.tx_valid = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk_int("post_reset_idle", int'({dp_tx_o, dn_tx_o, tx_en_o}), 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
